// File: rtl/chain_sink.sv
// chain_sink: terminal responder for the dut chain. Writes land in a small
// register bank, reads answer one cycle later, and saturating counters plus
// a sticky error flag record the traffic.

// One bank entry: stored data word and its saturating write counter.
module chain_sink_entry #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              clr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  wcnt
);
  logic [DATA_W-1:0] mem_q, mem_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;

  // next data and counter; clr beats the increment, but never blocks the data write
  always_comb begin
    mem_d  = we ? wdata : mem_q;
    wcnt_d = wcnt_q;
    if (clr)                wcnt_d = '0;
    else if (we && !(&wcnt_q)) wcnt_d = wcnt_q + CNT_W'(1);
  end

  // entry state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wcnt_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign rdata = mem_q;
  assign wcnt  = wcnt_q;
endmodule

module chain_sink #(
  parameter int ADR_W  = 2,
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        cmd,
  input  logic [ADR_W-1:0]  adr,
  input  logic [DATA_W-1:0] data,
  input  logic              clr,
  output logic              rsp_valid,
  output logic [ADR_W-1:0]  rsp_adr,
  output logic [DATA_W-1:0] rsp_data,
  input  logic [ADR_W-1:0]  cnt_sel,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_total,
  output logic [CNT_W-1:0]  wr_total,
  output logic              err,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int NENT = 2**ADR_W;

  typedef enum logic [1:0] {CMD_NOP = 2'd0, CMD_WR = 2'd1, CMD_RD = 2'd2, CMD_ILL = 2'd3} cmd_e;

  cmd_e cmd_s;
  assign cmd_s = cmd_e'(cmd);

  logic [NENT-1:0][DATA_W-1:0] mem_rd;
  logic [NENT-1:0][CNT_W-1:0]  wcnt;
  logic [NENT-1:0]             we;

  logic              rsp_valid_q, rsp_valid_d;
  logic [ADR_W-1:0]  rsp_adr_q, rsp_adr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]  rd_total_q, rd_total_d;
  logic [CNT_W-1:0]  wr_total_q, wr_total_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              err_q, err_d;

  // address decode into per-entry write enables
  always_comb begin
    we = '0;
    if (cmd_s == CMD_WR) we[adr] = 1'b1;
  end

  genvar i;
  generate
    for (i = 0; i < NENT; i++) begin : g_ent
      chain_sink_entry #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_ent (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we[i]),
        .clr   (clr),
        .wdata (data),
        .rdata (mem_rd[i]),
        .wcnt  (wcnt[i])
      );
    end
  endgenerate

  // response and global counter next-state; rsp_adr/rsp_data hold between reads
  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_adr_d   = rsp_adr_q;
    rsp_data_d  = rsp_data_q;
    rd_total_d  = rd_total_q;
    wr_total_d  = wr_total_q;
    err_cnt_d   = err_cnt_q;
    err_d       = err_q;
    unique case (cmd_s)
      CMD_RD: begin
        rsp_valid_d = 1'b1;
        rsp_adr_d   = adr;
        rsp_data_d  = mem_rd[adr];
        if (!(&rd_total_q)) rd_total_d = rd_total_q + CNT_W'(1);
      end
      CMD_WR:  if (!(&wr_total_q)) wr_total_d = wr_total_q + CNT_W'(1);
      CMD_ILL: begin
        err_d = 1'b1;
        if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
    if (clr) begin
      rd_total_d = '0;
      wr_total_d = '0;
      err_cnt_d  = '0;
      err_d      = 1'b0;
    end
  end

  // response and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_adr_q   <= '0;
      rsp_data_q  <= '0;
      rd_total_q  <= '0;
      wr_total_q  <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_adr_q   <= rsp_adr_d;
      rsp_data_q  <= rsp_data_d;
      rd_total_q  <= rd_total_d;
      wr_total_q  <= wr_total_d;
      err_cnt_q   <= err_cnt_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_adr   = rsp_adr_q;
  assign rsp_data  = rsp_data_q;
  assign rd_total  = rd_total_q;
  assign wr_total  = wr_total_q;
  assign err_cnt   = err_cnt_q;
  assign err       = err_q;
  assign wr_cnt    = wcnt[cnt_sel];
endmodule

// File: tb/tb_chain_sink.sv
// tb_chain_sink: directed stimulus with a reference model and a response
// scoreboard queue; reads push expected (adr,data), responses pop and compare.
module tb_chain_sink;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cmd = '0;
  logic [1:0] adr = '0;
  logic [2:0] data = '0;
  logic       clr = 1'b0;
  logic [1:0] cnt_sel = '0;
  logic       rsp_valid;
  logic [1:0] rsp_adr;
  logic [2:0] rsp_data;
  logic [7:0] wr_cnt, rd_total, wr_total, err_cnt;
  logic       err;

  chain_sink dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .adr(adr), .data(data), .clr(clr),
    .rsp_valid(rsp_valid), .rsp_adr(rsp_adr), .rsp_data(rsp_data),
    .cnt_sel(cnt_sel), .wr_cnt(wr_cnt), .rd_total(rd_total),
    .wr_total(wr_total), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  // reference model
  logic [2:0] m_mem [4];
  int         m_wcnt [4];
  int         m_wr, m_rd, m_errc;
  logic       m_err;
  logic [2:0] m_last_data;
  logic [1:0] m_last_adr;
  logic [4:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin m_mem[k] = '0; m_wcnt[k] = 0; end
    m_wr = 0; m_rd = 0; m_errc = 0; m_err = 1'b0;
    m_last_data = '0; m_last_adr = '0;
    sb.delete();
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, ".wr_total"}, 32'(wr_total), 32'(m_wr));
    chk({tag, ".rd_total"}, 32'(rd_total), 32'(m_rd));
    chk({tag, ".err_cnt"},  32'(err_cnt),  32'(m_errc));
    chk({tag, ".err"},      32'(err),      32'(m_err));
    chk({tag, ".wr_cnt"},   32'(wr_cnt),   32'(m_wcnt[cnt_sel]));
    chk({tag, ".rsp_data"}, 32'(rsp_data), 32'(m_last_data));
    chk({tag, ".rsp_adr"},  32'(rsp_adr),  32'(m_last_adr));
  endtask

  // drive one command for one clock, update the model, check after the edge
  task automatic cyc(input string tag, input logic [1:0] c, input logic [1:0] a,
                     input logic [2:0] d, input logic cl);
    logic [4:0] e;
    cmd = c; adr = a; data = d; clr = cl;
    if (c == 2'd2) begin
      sb.push_back({a, m_mem[a]});
      m_rd = sat(m_rd);
    end
    if (c == 2'd1) begin
      m_mem[a] = d;
      m_wcnt[a] = sat(m_wcnt[a]);
      m_wr = sat(m_wr);
    end
    if (c == 2'd3) begin
      m_err = 1'b1;
      m_errc = sat(m_errc);
    end
    if (cl) begin
      for (int k = 0; k < 4; k++) m_wcnt[k] = 0;
      m_wr = 0; m_rd = 0; m_errc = 0; m_err = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(c == 2'd2));
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) chk({tag, ".sb_empty"}, 32'(rsp_valid), 32'(0));
      else begin
        e = sb.pop_front();
        m_last_adr = e[4:3];
        m_last_data = e[2:0];
      end
    end
    chk_state(tag);
  endtask

  initial begin
    model_reset();
    // reset held with random inputs
    for (int k = 0; k < 4; k++) begin
      cmd = 2'($urandom_range(0, 3)); adr = 2'($urandom); data = 3'($urandom);
      clr = 1'($urandom); cnt_sel = 2'($urandom);
      @(posedge clk); #1;
      chk("rst.rsp_valid", 32'(rsp_valid), 32'(0));
      chk_state("rst");
    end
    cmd = '0; clr = 1'b0; cnt_sel = 2'd1;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cyc("nop", 2'd0, 2'($urandom), 3'($urandom), 1'b0);

    // write / read-back, back-to-back reads
    cyc("wr1", 2'd1, 2'd1, 3'd5, 1'b0);
    cyc("wr2", 2'd1, 2'd2, 3'd7, 1'b0);
    cyc("rd1", 2'd2, 2'd1, 3'd0, 1'b0);
    cyc("rd2", 2'd2, 2'd2, 3'd0, 1'b0);
    cyc("hold", 2'd0, 2'd0, 3'd0, 1'b0);
    chk("wb.wr_cnt1", 32'(wr_cnt), 32'(1));
    chk("wb.wr_total", 32'(wr_total), 32'(2));
    chk("wb.rd_total", 32'(rd_total), 32'(2));
    // write then immediate read of the same address
    cyc("wrx", 2'd1, 2'd3, 3'd6, 1'b0);
    cyc("rdx", 2'd2, 2'd3, 3'd0, 1'b0);

    // saturation
    cnt_sel = 2'd2;
    for (int k = 0; k < 300; k++) cyc("sat", 2'd1, 2'd2, 3'(k % 8), 1'b0);
    chk("sat.wr_cnt2", 32'(wr_cnt), 32'(255));
    chk("sat.wr_total", 32'(wr_total), 32'(255));
    cyc("sat_rd", 2'd2, 2'd2, 3'd0, 1'b0);
    chk("sat.rd_data", 32'(rsp_data), 32'(3));
    // wr_cnt follows cnt_sel combinationally
    for (int k = 0; k < 4; k++) begin
      cnt_sel = 2'(k); #1;
      chk("sel.wr_cnt", 32'(wr_cnt), 32'(m_wcnt[k]));
    end

    // illegal command, then clear
    cyc("ill", 2'd3, 2'd1, 3'd0, 1'b0);
    cyc("ill", 2'd3, 2'd2, 3'd1, 1'b0);
    chk("ill.err", 32'(err), 32'(1));
    chk("ill.err_cnt", 32'(err_cnt), 32'(2));
    cyc("clr", 2'd0, 2'd0, 3'd0, 1'b1);
    cyc("ill_rd", 2'd2, 2'd1, 3'd0, 1'b0);
    chk("ill.rd1", 32'(rsp_data), 32'(5));
    cyc("clr_ill", 2'd3, 2'd0, 3'd0, 1'b1);

    // clear together with write and with read
    cnt_sel = 2'd1;
    cyc("clr_wr", 2'd1, 2'd1, 3'd3, 1'b1);
    chk("clrwr.wr_cnt1", 32'(wr_cnt), 32'(0));
    cyc("clr_rd", 2'd2, 2'd1, 3'd0, 1'b1);
    chk("clrrd.data", 32'(rsp_data), 32'(3));
    cyc("rd_b2b", 2'd2, 2'd0, 3'd0, 1'b0);
    cyc("rd_b2b", 2'd2, 2'd3, 3'd0, 1'b0);

    // mid-stream reset kills the pending response
    cmd = 2'd2; adr = 2'd2; clr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    model_reset();
    chk("mrst.rsp_valid", 32'(rsp_valid), 32'(0));
    chk_state("mrst");
    cmd = 2'd0;
    @(negedge clk); rst_n = 1'b1;
    cyc("mrst_rd", 2'd2, 2'd2, 3'd0, 1'b0);
    chk("mrst.rd2", 32'(rsp_data), 32'(0));
    cyc("end", 2'd0, 2'd0, 3'd0, 1'b0);
    chk("sb.drained", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  // global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
